// File: rtl/digit_entry_ctrl.sv
// Operand-entry controller: editable digit bank, per-operand radix conversion and a
// start/done handshake to the CPU with a watchdog on the wait phase.
module digit_entry_ctrl #(
  parameter int NUM_DIGITS     = 4,
  parameter int DIGITS_PER_OP  = 2,
  parameter int RADIX          = 10,
  parameter int OP_WIDTH       = 32,
  parameter int TIMEOUT_CYCLES = 1000000,
  localparam int NUM_OPS = NUM_DIGITS / DIGITS_PER_OP,
  localparam int CW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        btn_up,
  input  logic                        btn_down,
  input  logic                        btn_left,
  input  logic                        btn_right,
  input  logic                        btn_clear,
  input  logic                        btn_start,
  input  logic                        cpu_done,
  output logic [4*NUM_DIGITS-1:0]     digits,
  output logic [CW-1:0]               cursor,
  output logic [OP_WIDTH*NUM_OPS-1:0] operands,
  output logic                        calc_start,
  output logic                        busy,
  output logic                        done,
  output logic                        timeout
);

  localparam int KW      = (DIGITS_PER_OP > 1) ? $clog2(DIGITS_PER_OP) : 1;
  localparam int TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TmoLast = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam longint unsigned MaxVal = 64'(RADIX) ** DIGITS_PER_OP;

  localparam logic [OP_WIDTH-1:0] RadixW = OP_WIDTH'(RADIX);
  localparam logic [3:0]          DigMax = 4'(RADIX - 1);
  localparam logic [CW-1:0]       CurMax = CW'(NUM_DIGITS - 1);

  if ((NUM_DIGITS < 2) || (NUM_DIGITS % DIGITS_PER_OP != 0) ||
      ((RADIX != 10) && (RADIX != 16)) || ($clog2(MaxVal) > OP_WIDTH)) begin : g_param_err
    $error("digit_entry_ctrl: illegal parameter combination");
  end

  typedef enum logic [1:0] {StIdle, StConvert, StStart, StWait} state_e;

  state_e                             state_q, state_d;
  logic [NUM_DIGITS-1:0][3:0]         digits_q, digits_d;
  logic [CW-1:0]                      cursor_q, cursor_d;
  logic [NUM_OPS-1:0][OP_WIDTH-1:0]   acc_q, acc_d;
  logic [NUM_OPS-1:0][OP_WIDTH-1:0]   ops_q, ops_d;
  logic [KW-1:0]                      conv_cnt_q, conv_cnt_d;
  logic [TW-1:0]                      wait_cnt_q, wait_cnt_d;
  logic                               calc_start_q, calc_start_d;
  logic                               done_q, done_d;
  logic                               timeout_q, timeout_d;
  logic [CW-1:0]                      sel;

  always_comb begin
    state_d      = state_q;
    digits_d     = digits_q;
    cursor_d     = cursor_q;
    acc_d        = acc_q;
    ops_d        = ops_q;
    conv_cnt_d   = conv_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    calc_start_d = 1'b0;
    done_d       = 1'b0;
    timeout_d    = timeout_q;
    sel          = '0;
    case (state_q)
      StIdle: begin
        if (btn_clear) begin
          digits_d  = '0;
          cursor_d  = '0;
          timeout_d = 1'b0;
        end else if (btn_start) begin
          timeout_d  = 1'b0;
          acc_d      = '0;
          conv_cnt_d = '0;
          state_d    = StConvert;
        end else begin
          // Edit uses the pre-move cursor.
          if (btn_up) begin
            digits_d[cursor_q] = (digits_q[cursor_q] == DigMax) ? 4'd0
                                                                 : digits_q[cursor_q] + 4'd1;
          end else if (btn_down) begin
            digits_d[cursor_q] = (digits_q[cursor_q] == 4'd0) ? DigMax
                                                               : digits_q[cursor_q] - 4'd1;
          end
          if (btn_right) begin
            cursor_d = (cursor_q == '0) ? CurMax : cursor_q - CW'(1);
          end else if (btn_left) begin
            cursor_d = (cursor_q == CurMax) ? '0 : cursor_q + CW'(1);
          end
        end
      end
      StConvert: begin
        for (int j = 0; j < NUM_OPS; j++) begin
          sel = CW'(j * DIGITS_PER_OP + DIGITS_PER_OP - 1 - int'(conv_cnt_q));
          acc_d[j] = acc_q[j] * RadixW + {{(OP_WIDTH-4){1'b0}}, digits_q[sel]};
        end
        if (conv_cnt_q == KW'(DIGITS_PER_OP - 1)) begin
          ops_d        = acc_d;
          calc_start_d = 1'b1;
          state_d      = StStart;
        end else begin
          conv_cnt_d = conv_cnt_q + KW'(1);
        end
      end
      StStart: begin
        wait_cnt_d = '0;
        state_d    = StWait;
      end
      StWait: begin
        if (cpu_done) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else if ((TIMEOUT_CYCLES != 0) && (wait_cnt_q == TW'(TmoLast))) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          wait_cnt_d = wait_cnt_q + TW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      digits_q     <= '0;
      cursor_q     <= '0;
      acc_q        <= '0;
      ops_q        <= '0;
      conv_cnt_q   <= '0;
      wait_cnt_q   <= '0;
      calc_start_q <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      digits_q     <= digits_d;
      cursor_q     <= cursor_d;
      acc_q        <= acc_d;
      ops_q        <= ops_d;
      conv_cnt_q   <= conv_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      calc_start_q <= calc_start_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
    end
  end

  assign digits     = digits_q;
  assign cursor     = cursor_q;
  assign operands   = ops_q;
  assign calc_start = calc_start_q;
  assign busy       = (state_q != StIdle);
  assign done       = done_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_digit_entry_ctrl.sv
// Drives a decimal and a hex instance from shared buttons and checks both against a
// transaction-level reference model every cycle.
module tb_digit_entry_ctrl;

  localparam int TMO = 16;
  // Button vector bit order: {start, clear, up, down, left, right, cpu_done}
  localparam logic [6:0] BStart = 7'b1000000;
  localparam logic [6:0] BClr   = 7'b0100000;
  localparam logic [6:0] BUp    = 7'b0010000;
  localparam logic [6:0] BDown  = 7'b0001000;
  localparam logic [6:0] BLeft  = 7'b0000100;
  localparam logic [6:0] BRight = 7'b0000010;
  localparam logic [6:0] BDone  = 7'b0000001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0;
  logic btn_clear = 0, btn_start = 0, cpu_done = 0;

  logic [15:0] dec_digits;
  logic [1:0]  dec_cursor;
  logic [63:0] dec_ops;
  logic        dec_cs, dec_busy, dec_done, dec_tmo;
  logic [31:0] hex_digits;
  logic [2:0]  hex_cursor;
  logic [63:0] hex_ops;
  logic        hex_cs, hex_busy, hex_done, hex_tmo;

  always #5 clk = ~clk;

  digit_entry_ctrl #(
    .NUM_DIGITS(4), .DIGITS_PER_OP(2), .RADIX(10), .OP_WIDTH(32), .TIMEOUT_CYCLES(TMO)
  ) u_dec (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_clear(btn_clear), .btn_start(btn_start), .cpu_done(cpu_done),
    .digits(dec_digits), .cursor(dec_cursor), .operands(dec_ops), .calc_start(dec_cs),
    .busy(dec_busy), .done(dec_done), .timeout(dec_tmo)
  );

  digit_entry_ctrl #(
    .NUM_DIGITS(8), .DIGITS_PER_OP(4), .RADIX(16), .OP_WIDTH(32), .TIMEOUT_CYCLES(TMO)
  ) u_hex (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_clear(btn_clear), .btn_start(btn_start), .cpu_done(cpu_done),
    .digits(hex_digits), .cursor(hex_cursor), .operands(hex_ops), .calc_start(hex_cs),
    .busy(hex_busy), .done(hex_done), .timeout(hex_tmo)
  );

  int vectors = 0;
  int errors  = 0;

  // Reference model: phase 0 idle, 1 converting, 2 start, 3 waiting.
  int     nd[2]  = '{4, 8};
  int     dpo[2] = '{2, 4};
  int     rdx[2] = '{10, 16};
  int     md[2][8];
  int     mcur[2];
  longint mops[2][2];
  int     mph[2];
  int     mcnt[2];
  bit     mcs[2], mdn[2], mtm[2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 8; k++) md[i][k] = 0;
      mcur[i] = 0; mops[i][0] = 0; mops[i][1] = 0;
      mph[i] = 0; mcnt[i] = 0; mcs[i] = 0; mdn[i] = 0; mtm[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      mcs[i] = 0;
      mdn[i] = 0;
      case (mph[i])
        0: begin
          if (btn_clear) begin
            for (int k = 0; k < 8; k++) md[i][k] = 0;
            mcur[i] = 0;
            mtm[i]  = 0;
          end else if (btn_start) begin
            mtm[i] = 0; mph[i] = 1; mcnt[i] = 0;
          end else begin
            if (btn_up) md[i][mcur[i]] = (md[i][mcur[i]] + 1) % rdx[i];
            else if (btn_down) md[i][mcur[i]] = (md[i][mcur[i]] + rdx[i] - 1) % rdx[i];
            if (btn_right) mcur[i] = (mcur[i] + nd[i] - 1) % nd[i];
            else if (btn_left) mcur[i] = (mcur[i] + 1) % nd[i];
          end
        end
        1: begin
          mcnt[i]++;
          if (mcnt[i] == dpo[i]) begin
            for (int j = 0; j < 2; j++) begin
              longint acc = 0;
              for (int p = dpo[i] - 1; p >= 0; p--) acc = acc * rdx[i] + md[i][j*dpo[i] + p];
              mops[i][j] = acc;
            end
            mcs[i] = 1;
            mph[i] = 2;
          end
        end
        2: begin
          mph[i] = 3; mcnt[i] = 0;
        end
        default: begin
          if (cpu_done) begin
            mdn[i] = 1; mph[i] = 0;
          end else begin
            mcnt[i]++;
            if (mcnt[i] == TMO) begin
              mtm[i] = 1; mph[i] = 0;
            end
          end
        end
      endcase
    end
  endtask

  function automatic logic [63:0] exp_dig(input int i);
    logic [63:0] e = '0;
    for (int k = 0; k < nd[i]; k++) e = e | (64'(md[i][k]) << (4 * k));
    return e;
  endfunction

  function automatic logic [63:0] exp_ops(input int i);
    return (64'(mops[i][1]) << 32) | 64'(mops[i][0]);
  endfunction

  task automatic check_all();
    check("dec_digits", 64'(dec_digits), exp_dig(0));
    check("dec_cursor", 64'(dec_cursor), 64'(mcur[0]));
    check("dec_operands", dec_ops, exp_ops(0));
    check("dec_calc_start", 64'(dec_cs), 64'(mcs[0]));
    check("dec_busy", 64'(dec_busy), 64'(mph[0] != 0));
    check("dec_done", 64'(dec_done), 64'(mdn[0]));
    check("dec_timeout", 64'(dec_tmo), 64'(mtm[0]));
    check("hex_digits", 64'(hex_digits), exp_dig(1));
    check("hex_cursor", 64'(hex_cursor), 64'(mcur[1]));
    check("hex_operands", hex_ops, exp_ops(1));
    check("hex_calc_start", 64'(hex_cs), 64'(mcs[1]));
    check("hex_busy", 64'(hex_busy), 64'(mph[1] != 0));
    check("hex_done", 64'(hex_done), 64'(mdn[1]));
    check("hex_timeout", 64'(hex_tmo), 64'(mtm[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1 check_all();
  endtask

  task automatic drive(input logic [6:0] b);
    {btn_start, btn_clear, btn_up, btn_down, btn_left, btn_right, cpu_done} = b;
  endtask

  task automatic press(input logic [6:0] b);
    drive(b);
    tick();
    drive(7'b0);
  endtask

  logic [6:0] seq1[13] = '{BDown, BDown, BLeft, BUp, BLeft, BUp, BUp, BLeft,
                           BUp, BUp, BUp, BUp, BStart};
  logic [6:0] seq2[8]  = '{BRight, BRight, BRight, BUp, BUp, BDown, BRight, BUp | BDown};
  logic [6:0] seq3[23] = '{BClr, BUp, BUp, BUp, BUp, BLeft, BUp, BUp, BUp, BLeft, BUp, BUp,
                           BLeft, BUp, BLeft, BDown, BLeft, BDown, BLeft, BDown, BLeft,
                           BDown, BStart};

  initial begin
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Decimal digits 4,2,1,8 (d3..d0) -> operands 42 and 18.
    foreach (seq1[n]) press(seq1[n]);
    for (int n = 0; n < 4; n++) tick();
    check("dec_item1_operands", dec_ops, 64'h0000002A_00000012);
    for (int n = 0; n < 6; n++) press(BDone);

    foreach (seq2[n]) press(seq2[n]);

    // Hex FFFF_1234.
    foreach (seq3[n]) press(seq3[n]);
    for (int n = 0; n < 6; n++) press(BUp | BStart | BClr);
    check("hex_item3_operands", hex_ops, 64'h0000FFFF_00001234);
    for (int n = 0; n < 24; n++) tick();
    for (int n = 0; n < 2; n++) press(BClr);

    // Async reset while converting.
    press(BUp);
    press(BStart);
    #2 rst = 1'b1;
    #1 model_reset();
    check_all();
    tick();
    rst = 1'b0;
    for (int n = 0; n < 4; n++) tick();

    for (int n = 0; n < 3000; n++) begin
      logic [6:0] b;
      b[6] = ($urandom_range(0, 19) == 0);
      b[5] = ($urandom_range(0, 49) == 0);
      b[4] = ($urandom_range(0, 3) == 0);
      b[3] = ($urandom_range(0, 3) == 0);
      b[2] = ($urandom_range(0, 3) == 0);
      b[1] = ($urandom_range(0, 3) == 0);
      b[0] = ($urandom_range(0, 7) == 0);
      press(b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
